// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller that drains a FIFO in bursts.
// Ports: rd_clk, sys_rst (async, active high); FIFO status in
// (rd_rst_busy, full, almost_empty, empty, fifo_rd_data); fifo_rd_en out;
// rd_data/rd_data_vld, rd_word_cnt, burst_done, busy, chk_err out.
// Optional macro FIFO_RD_CHECK_EN adds an incrementing-pattern checker.
module fifo_rd_ctrl #(
    parameter int DATA_W      = 8,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int BURST_LEN   = 0,
    parameter int START_MODE  = 0
) (
    input  logic              rd_clk,
    input  logic              sys_rst,
    input  logic              rd_rst_busy,
    input  logic              full,
    input  logic              almost_empty,
    input  logic              empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_vld,
    output logic [CNT_W-1:0]  rd_word_cnt,
    output logic              burst_done,
    output logic              busy,
    output logic              chk_err
);

    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    // Per-burst count value seen when the final read of a burst is issued.
    localparam logic [15:0] BURST_LAST =
        (BURST_LEN == 0) ? 16'd0 : 16'(BURST_LEN - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [15:0]            bcnt_q, bcnt_d;
    logic                   pend_q, pend_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   vld_q, vld_d;
    logic [CNT_W-1:0]       wcnt_q, wcnt_d;
    logic                   done_q, done_d;
    logic                   full_s;
    logic                   start;
    logic                   last_rd;

    assign full_s     = sync_q[SYNC_STAGES-1];
    assign start      = (START_MODE == 0) ? full_s : !empty;
    assign fifo_rd_en = (state_q == READ) && !empty && !rd_rst_busy;
    assign last_rd    = fifo_rd_en &&
                        (almost_empty ||
                         (BURST_LEN != 0 && bcnt_q == BURST_LAST));

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], full};
        state_d = state_q;
        bcnt_d  = bcnt_q;
        unique case (state_q)
            IDLE: begin
                if (!rd_rst_busy && start) begin
                    state_d = READ;
                    bcnt_d  = '0;
                end
            end
            READ: begin
                // FIFO reset aborts silently; no burst_done.
                if (rd_rst_busy) begin
                    state_d = IDLE;
                    bcnt_d  = '0;
                end else if (empty) begin
                    state_d = DONE;
                end else begin
                    bcnt_d = bcnt_q + 16'd1;
                    if (last_rd) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // FIFO data lands one cycle after the strobe; register it once more.
        pend_d = fifo_rd_en;
        vld_d  = pend_q;
        data_d = pend_q ? fifo_rd_data : data_q;
        wcnt_d = pend_q ? wcnt_q + 1'b1 : wcnt_q;
        done_d = (state_d == DONE);
    end

    always_ff @(posedge rd_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            sync_q  <= '0;
            bcnt_q  <= '0;
            pend_q  <= 1'b0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            wcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            bcnt_q  <= bcnt_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            wcnt_q  <= wcnt_d;
            done_q  <= done_d;
        end
    end

    assign rd_data     = data_q;
    assign rd_data_vld = vld_q;
    assign rd_word_cnt = wcnt_q;
    assign burst_done  = done_q;
    assign busy        = (state_q != IDLE);

`ifdef FIFO_RD_CHECK_EN
    logic              seed_q, seed_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic              err_q, err_d;

    always_comb begin
        seed_d = seed_q;
        exp_d  = exp_q;
        err_d  = err_q;
        if (vld_q) begin
            exp_d = data_q + 1'b1;
            if (seed_q) begin
                seed_d = 1'b0;
            end else if (data_q != exp_q) begin
                err_d = 1'b1;
            end
        end
        // Applied after the vld handling so a trailing word of the
        // previous burst is still checked against that burst.
        if (state_q == IDLE && state_d == READ) begin
            seed_d = 1'b1;
        end
    end

    always_ff @(posedge rd_clk or posedge sys_rst) begin
        if (sys_rst) begin
            seed_q <= 1'b0;
            exp_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            seed_q <= seed_d;
            exp_q  <= exp_d;
            err_q  <= err_d;
        end
    end

    assign chk_err = err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed bench for fifo_rd_ctrl, three configurations
// (drain-on-full, 4-word bursts, 4-bit word counter).
module tb_fifo_rd_ctrl;

    logic rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

`ifdef FIFO_RD_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
    logic rb0 = 1'b0, rb1 = 1'b0, rb2 = 1'b0;
    logic fu0 = 1'b0, fu1 = 1'b0, fu2 = 1'b0;
    logic ae0 = 1'b1, ae1 = 1'b1, ae2 = 1'b1;
    logic em0 = 1'b1, em1 = 1'b1, em2 = 1'b1;
    logic [7:0] rdd0 = '0, rdd1 = '0, rdd2 = '0;
    logic en0, en1, en2;
    logic [7:0] dat0, dat1, dat2;
    logic vld0, vld1, vld2;
    logic [15:0] cnt0, cnt1;
    logic [3:0] cnt2;
    logic bd0, bd1, bd2;
    logic busy0, busy1, busy2;
    logic ce0, ce1, ce2;

    fifo_rd_ctrl #(.DATA_W(8), .CNT_W(16), .SYNC_STAGES(2),
                   .BURST_LEN(0), .START_MODE(0)) u0 (
        .rd_clk(rd_clk), .sys_rst(rst0), .rd_rst_busy(rb0),
        .full(fu0), .almost_empty(ae0), .empty(em0),
        .fifo_rd_data(rdd0), .fifo_rd_en(en0), .rd_data(dat0),
        .rd_data_vld(vld0), .rd_word_cnt(cnt0), .burst_done(bd0),
        .busy(busy0), .chk_err(ce0));

    fifo_rd_ctrl #(.DATA_W(8), .CNT_W(16), .SYNC_STAGES(2),
                   .BURST_LEN(4), .START_MODE(1)) u1 (
        .rd_clk(rd_clk), .sys_rst(rst1), .rd_rst_busy(rb1),
        .full(fu1), .almost_empty(ae1), .empty(em1),
        .fifo_rd_data(rdd1), .fifo_rd_en(en1), .rd_data(dat1),
        .rd_data_vld(vld1), .rd_word_cnt(cnt1), .burst_done(bd1),
        .busy(busy1), .chk_err(ce1));

    fifo_rd_ctrl #(.DATA_W(8), .CNT_W(4), .SYNC_STAGES(2),
                   .BURST_LEN(0), .START_MODE(1)) u2 (
        .rd_clk(rd_clk), .sys_rst(rst2), .rd_rst_busy(rb2),
        .full(fu2), .almost_empty(ae2), .empty(em2),
        .fifo_rd_data(rdd2), .fifo_rd_en(en2), .rd_data(dat2),
        .rd_data_vld(vld2), .rd_word_cnt(cnt2), .burst_done(bd2),
        .busy(busy2), .chk_err(ce2));

    // FIFO models: 1-cycle read latency, depth 256.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [7:0] wp0 = '0;
    logic [7:0] wp2 = '0;

    always @(posedge rd_clk) begin
        if (en0 && q0.size() > 0) rdd0 <= q0.pop_front();
        if (en1 && q1.size() > 0) rdd1 <= q1.pop_front();
        if (en2 && q2.size() > 0) rdd2 <= q2.pop_front();
    end

    always @(posedge rd_clk) begin
        #2;
        em0 = (q0.size() == 0);
        ae0 = (q0.size() <= 1);
        fu0 = (q0.size() >= 256);
        em1 = (q1.size() == 0);
        ae1 = (q1.size() <= 1);
        fu1 = (q1.size() >= 256);
        em2 = (q2.size() == 0);
        ae2 = (q2.size() <= 1);
        fu2 = (q2.size() >= 256);
    end

    task automatic push0(input int n);
        for (int i = 0; i < n; i++) begin
            q0.push_back(wp0);
            wp0 = wp0 + 8'd1;
        end
    endtask

    task automatic push2(input int n);
        for (int i = 0; i < n; i++) begin
            q2.push_back(wp2);
            wp2 = wp2 + 8'd1;
        end
    endtask

    // Monitors: vld words are expected in push order (0,1,2,...).
    int vcnt0 = 0, derr0 = 0, bdn0 = 0;
    int vcnt1 = 0, derr1 = 0, bdn1 = 0, br1 = 0, cur1 = 0;
    int vcnt2 = 0, derr2 = 0, bdn2 = 0;
    int bl1[$];
    logic busy1_p = 1'b0;

    always @(negedge rd_clk) begin
        if (vld0) begin
            if (dat0 !== 8'(vcnt0)) derr0++;
            vcnt0++;
        end
        if (bd0) bdn0++;
        if (vld1) begin
            if (dat1 !== 8'(vcnt1)) derr1++;
            vcnt1++;
        end
        if (bd1) bdn1++;
        if (en1) cur1++;
        if (busy1 && !busy1_p) br1++;
        if (!busy1 && busy1_p) begin
            bl1.push_back(cur1);
            cur1 = 0;
        end
        busy1_p = busy1;
        if (vld2) begin
            if (dat2 !== 8'(vcnt2)) derr2++;
            vcnt2++;
        end
        if (bd2) bdn2++;
    end

    int cyc;
    int k;
    logic found;
    int be[3] = '{4, 4, 2};

    initial begin
        #2;
        check("rst_u0", {en0, vld0, dat0, cnt0, bd0, busy0, ce0}, 0);
        check("rst_u1", {en1, vld1, dat1, cnt1, bd1, busy1, ce1}, 0);
        check("rst_u2", {en2, vld2, dat2, cnt2, bd2, busy2, ce2}, 0);
        #10;
        rst0 = 1'b0;
        rst1 = 1'b0;
        rst2 = 1'b0;

        // Drain 256 words once full is seen.
        @(posedge rd_clk); #1;
        push0(256);
        @(negedge rd_clk);
        check("lat_en_low", en0, 0);
        cyc = 0;
        while (!en0 && cyc < 10) begin
            @(negedge rd_clk);
            cyc++;
        end
        check("full_to_rd_en", cyc, 3);
        repeat (300) @(negedge rd_clk);
        check("drain_vld_cnt", vcnt0, 256);
        check("drain_data_err", derr0, 0);
        check("drain_word_cnt", cnt0, 256);
        check("drain_bdone", bdn0, 1);
        check("drain_chk_err", ce0, 0);
        check("drain_idle", busy0, 0);

        // rd_rst_busy abort after five reads.
        @(posedge rd_clk); #1;
        push0(256);
        k = 0;
        cyc = 0;
        while (k < 5 && cyc < 20) begin
            @(negedge rd_clk);
            cyc++;
            if (en0) k++;
        end
        check("abort_reads_seen", k, 5);
        @(posedge rd_clk); #1;
        rb0 = 1'b1;
        #1;
        check("abort_en_same", en0, 0);
        check("abort_still_read", busy0, 1);
        @(posedge rd_clk); #1;
        check("abort_idle_next", busy0, 0);
        repeat (2) @(posedge rd_clk);
        #1;
        rb0 = 1'b0;
        repeat (10) @(negedge rd_clk);
        check("abort_bdone", bdn0, 1);
        check("abort_vld_cnt", vcnt0, 261);
        check("abort_word_cnt", cnt0, 261);
        check("abort_stay_idle", busy0, 0);

        // sys_rst in the middle of a burst.
        @(posedge rd_clk); #1;
        push0(5);
        k = 0;
        cyc = 0;
        while (k < 3 && cyc < 20) begin
            @(negedge rd_clk);
            cyc++;
            if (en0) k++;
        end
        check("srst_reads_seen", k, 3);
        @(posedge rd_clk); #2;
        rst0 = 1'b1;
        #1;
        check("srst_async_zero",
              {en0, vld0, dat0, cnt0, bd0, busy0, ce0}, 0);
        @(negedge rd_clk);
        rst0 = 1'b0;
        repeat (10) @(negedge rd_clk);
        check("srst_stay_idle", {busy0, en0}, 0);

        // Bursts of 4 on a 10-word FIFO.
        @(posedge rd_clk); #1;
        for (int i = 0; i < 10; i++) q1.push_back(8'(i));
        repeat (40) @(negedge rd_clk);
        check("burst_bdone", bdn1, 3);
        check("burst_vld_cnt", vcnt1, 10);
        check("burst_data_err", derr1, 0);
        check("burst_busy_rises", br1, 3);
        check("burst_n_lens", bl1.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("burst_len%0d", i),
                  (i < bl1.size()) ? bl1[i] : -1, be[i]);
        check("burst_word_cnt", cnt1, 10);
        check("burst_chk_ok", ce1, 0);

        // Pattern checker: 0,1,2,4 then a clean burst.
        @(posedge rd_clk); #1;
        q1.push_back(8'd0);
        q1.push_back(8'd1);
        q1.push_back(8'd2);
        q1.push_back(8'd4);
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 40) begin
            @(negedge rd_clk);
            cyc++;
            if (vld1 && dat1 == 8'd4) found = 1'b1;
        end
        check("chk_vld4_seen", found, 1);
        check("chk_err_before", ce1, 0);
        @(negedge rd_clk);
        check("chk_err_after", ce1, EXP_ERR);
        repeat (20) @(negedge rd_clk);
        @(posedge rd_clk); #1;
        for (int i = 10; i < 14; i++) q1.push_back(8'(i));
        repeat (30) @(negedge rd_clk);
        check("chk_err_sticky", ce1, EXP_ERR);
        check("chk_bdone", bdn1, 5);

        // 4-bit counter wraps: 18 words -> 2.
        @(posedge rd_clk); #1;
        push2(18);
        repeat (40) @(negedge rd_clk);
        check("wrap_vld_cnt", vcnt2, 18);
        check("wrap_word_cnt", cnt2, 2);
        check("wrap_bdone", bdn2, 1);
        check("wrap_data_err", derr2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
